// File: rtl/dice_roller.sv
// Dice roller: debounced button starts a roll, release decelerates, settles.
// Ports: clk, rst (sync high), start (raw button) -> dice, rolling, valid.
// DICE_LFSR_EN: pseudo-random face offsets instead of plain increment.
module dice_roller #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int ROLL_DIV        = 50000,
  parameter int SLOW_STEPS      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] dice,
  output logic       rolling,
  output logic       valid
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2((ROLL_DIV << SLOW_STEPS) + 1);
  localparam int NW = $clog2(SLOW_STEPS + 1);

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    SLOW,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic          s1;
  logic          s2;
  logic          deb;
  logic [DW-1:0] db_cnt;
  logic          db_hit;
  logic          press;
  logic          rel;

  logic [TW-1:0] tmr;
  logic [TW-1:0] lim;
  logic          tick;
  logic [NW-1:0] step;

  logic          adv;
  logic          tmr_clr;
  logic          step_ld;
  logic          step_inc;
  logic [3:0]    dice_nx;

  // Press/release fire on the edge where the debounced level flips.
  assign db_hit = (s2 != deb) &&
                  (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign press  = db_hit & s2;
  assign rel    = db_hit & ~s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      deb    <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= start;
      s2 <= s1;
      if (s2 != deb) begin
        if (db_hit) begin
          deb    <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Step period doubles with each deceleration step.
  always_comb begin
    lim = TW'(ROLL_DIV) - TW'(1);
    if (state == SLOW) begin
      lim = (TW'(ROLL_DIV) << step) - TW'(1);
    end
  end

  assign tick = (tmr == lim);

`ifdef DICE_LFSR_EN
  logic [7:0] lfsr;
  logic [2:0] off;
  logic [3:0] sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0],
               lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // Offset 1..5 is never a multiple of 6, so the face always moves.
  assign off = (lfsr[2:0] > 3'd4) ? lfsr[2:0] - 3'd4
                                  : lfsr[2:0] + 3'd1;

  always_comb begin
    sum     = dice - 4'd1 + {1'b0, off};
    dice_nx = {1'b0, off};
    if (dice != 4'd0) begin
      dice_nx = (sum >= 4'd6) ? sum - 4'd5 : sum + 4'd1;
    end
  end
`else
  always_comb begin
    dice_nx = (dice == 4'd6) ? 4'd1 : dice + 4'd1;
  end
`endif

  always_comb begin
    state_nx = state;
    adv      = 1'b0;
    tmr_clr  = 1'b0;
    step_ld  = 1'b0;
    step_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (press) begin
          state_nx = ROLL;
          tmr_clr  = 1'b1;
        end
      end
      ROLL: begin
        adv     = tick;
        tmr_clr = tick;
        if (rel) begin
          state_nx = SLOW;
          tmr_clr  = 1'b1;
          step_ld  = 1'b1;
        end
      end
      SLOW: begin
        if (tick) begin
          adv     = 1'b1;
          tmr_clr = 1'b1;
          if (step == NW'(SLOW_STEPS)) begin
            state_nx = DONE;
          end else begin
            step_inc = 1'b1;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign rolling = (state == ROLL) || (state == SLOW);
  assign valid   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tmr   <= '0;
      step  <= '0;
      dice  <= 4'd0;
    end else begin
      state <= state_nx;
      if (tmr_clr || !rolling) begin
        tmr <= '0;
      end else begin
        tmr <= tmr + 1'b1;
      end
      if (step_ld) begin
        step <= NW'(1);
      end else if (step_inc) begin
        step <= step + 1'b1;
      end
      if (adv) begin
        dice <= dice_nx;
      end
    end
  end

endmodule

// File: tb/tb_dice_roller.sv
// Randomized bench for dice_roller against an event-schedule model.
// Define DICE_LFSR_EN to exercise the pseudo-random face mode.
module tb_dice_roller;

  localparam int DB = 4;
  localparam int RD = 3;
  localparam int SS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dice;
  logic       rolling;
  logic       valid;

  int n_chk = 0;
  int n_pass = 0;
  int dice_model = 0;
  bit [6:0] seen = '0;

  always #5 clk = ~clk;

  dice_roller #(
    .DEBOUNCE_CYCLES(DB),
    .ROLL_DIV(RD),
    .SLOW_STEPS(SS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dice(dice),
    .rolling(rolling),
    .valid(valid)
  );

  task automatic check(input string tag, input int got,
                       input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic int adv_inc(input int d);
    return (d == 6) ? 1 : d + 1;
  endfunction

  // One press/hold/release; optional second press during deceleration.
  task automatic roll(input int hold, input bit extra);
    int t, rs, vt, nval, rv, rel, acc, v, p;
    int ch_t[$];
    int ch_v[$];
    int ex_t[$];
    bit done;
    rs = -1; vt = -1; nval = 0; rv = 0; done = 0;
    p = dice;
    @(negedge clk);
    start = 1'b1;
    t = 0;
    while (!done && t < 800) begin
      @(negedge clk);
      t++;
      if (t == hold) start = 1'b0;
      if (extra && t == hold + 15) start = 1'b1;
      if (extra && t == hold + 30) start = 1'b0;
      if (rolling && rs < 0) rs = t;
      if (int'(dice) != p) begin
        ch_t.push_back(t);
        ch_v.push_back(int'(dice));
        p = dice;
      end
      if (valid) begin
        nval++;
        if (vt < 0) begin
          vt = t;
          rv = rolling;
        end
      end
      if (vt >= 0 && t >= vt + 10) done = 1;
    end
    start = 1'b0;
    check("budget", done, 1);
    check("roll_lat", (rs >= 6 && rs <= 7), 1);
    // Release takes the same sync+debounce path as the press.
    rel = hold + rs;
    for (int k = 1; rs + RD * k <= rel; k++)
      ex_t.push_back(rs + RD * k);
    acc = rel;
    for (int n = 1; n <= SS; n++) begin
      acc += RD << n;
      ex_t.push_back(acc);
    end
    check("n_adv", ch_t.size(), ex_t.size());
    v = dice_model;
    p = dice_model;
    foreach (ex_t[i]) begin
`ifdef DICE_LFSR_EN
      if (i < ch_t.size()) begin
        check("adv_t", ch_t[i], ex_t[i]);
        check("face_rng", (ch_v[i] >= 1 && ch_v[i] <= 6), 1);
        check("face_chg", (ch_v[i] != p), 1);
        if (ch_v[i] >= 1 && ch_v[i] <= 6) seen[ch_v[i]] = 1'b1;
        p = ch_v[i];
      end
`else
      v = adv_inc(v);
      if (i < ch_t.size()) begin
        check("adv_t", ch_t[i], ex_t[i]);
        check("adv_v", ch_v[i], v);
      end
`endif
    end
    check("valid_n", nval, 1);
    check("valid_t", vt, ex_t[$]);
    check("roll_at_v", rv, 0);
    check("roll_end", rolling, 0);
`ifdef DICE_LFSR_EN
    check("dice_hold", dice, p);
    dice_model = p;
`else
    check("dice_hold", dice, v);
    dice_model = v;
`endif
  endtask

  task automatic bounce();
    int rl, vl, chg;
    rl = 0; vl = 0; chg = 0;
    check("bn_pre", dice, dice_model);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = (i < 30) ? ((i / 2) % 2 == 0) : 1'b0;
      if (rolling) rl++;
      if (valid) vl++;
      if (int'(dice) != dice_model) chg++;
    end
    check("bn_roll", rl, 0);
    check("bn_valid", vl, 0);
    check("bn_dice", chg, 0);
  endtask

  task automatic reset_test();
    int t, vl;
    @(negedge clk);
    start = 1'b1;
    t = 0;
    while (!rolling && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("rt_roll", rolling, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rt_dice", dice, 0);
    check("rt_rolling", rolling, 0);
    check("rt_valid0", valid, 0);
    rst = 1'b0;
    t = 0; vl = 0;
    while (!rolling && t < 30) begin
      @(negedge clk);
      t++;
      if (valid) vl++;
    end
    check("rt_relat", (t >= 6 && t <= 7), 1);
    check("rt_nov", vl, 0);
    start = 1'b0;
    t = 0;
    while (!valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("rt_done", valid, 1);
    check("rt_face", (dice >= 4'd1 && dice <= 4'd6), 1);
    @(negedge clk);
    check("rt_idle", rolling, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rt_clr", dice, 0);
    dice_model = 0;
  endtask

  initial begin
    int rl, vl, dz;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dice", dice, 0);
    check("rst_rolling", rolling, 0);
    check("rst_valid", valid, 0);
    rst = 1'b0;
    rl = 0; vl = 0; dz = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rolling) rl++;
      if (valid) vl++;
      if (dice != 4'd0) dz++;
    end
    check("idle_roll", rl, 0);
    check("idle_valid", vl, 0);
    check("idle_dice", dz, 0);

    roll(40, 1'b0);
    bounce();
    roll(20, 1'b1);
    roll(12, 1'b0);
    reset_test();
`ifdef DICE_LFSR_EN
    for (int r = 0; r < 200; r++)
      roll(int'($urandom_range(8, 14)), 1'b0);
    for (int f = 1; f <= 6; f++)
      check("face_seen", seen[f], 1);
`else
    for (int r = 0; r < 20; r++)
      roll(int'($urandom_range(6, 40)),
           1'($urandom_range(0, 1)));
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
